m_handshake_assert: RTL
=======================

# m_handshake_assert

Sequential protocol checker that watches a req/ack handshake and generates a registered violation strobe plus error code. Its `err` output is designed to drive the `expr` input of the team's simulation assertion block, which halts the simulation when that input fires. It also keeps a sticky error count for waveform and regression triage. The block contains no synthesis-relevant datapath; it is instantiated beside linked-list command interfaces in simulation builds.

## Interface
- `TIMEOUT`, 16: max edges after first req sample in which ack is accepted; legal range ≥ 1.
- `CNT_W`, 8: width of `err_cnt`.
- `clk`  input  1  clock; all sampling on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `enable`  input  1  1 = checking active; 0 = FSM forced to IDLE, no errors raised.
- `req`  input  1  request from initiator, must hold high until ack.
- `ack`  input  1  single-cycle acknowledge from responder.
- `busy`  output  1  1 while FSM in WAIT or HOLD.
- `err`  output  1  one-cycle pulse, registered, per violation.
- `err_code`  output  2  code of most recent violation: 0 none, 1 REQ_DROP, 2 ACK_NO_REQ, 3 TIMEOUT.
- `err_cnt`  output  CNT_W  total violations since reset, saturating at all-ones.

## Operation
- States: IDLE, WAIT, HOLD. Wait counter `wcnt` width $clog2(TIMEOUT+1).
- IDLE:
  - req=1, ack=1: zero-wait transfer, stay IDLE.
  - req=1, ack=0: go to WAIT, wcnt←1.
  - req=0, ack=1: ACK_NO_REQ violation, stay IDLE.
- WAIT:
  - ack=1: transfer complete, go to IDLE; req value that edge is ignored.
  - ack=0, req=0: REQ_DROP violation, go to IDLE.
  - ack=0, req=1, wcnt==TIMEOUT: TIMEOUT violation, go to HOLD.
  - Otherwise wcnt←wcnt+1.
- HOLD: no further violations raised for this request. Exit to IDLE on ack=1 or req=0; a late ack there is absorbed, not flagged.
- On each violation:
  - err=1 for exactly the following cycle.
  - err_code←code, held until the next violation.
  - err_cnt←err_cnt+1, saturating at 2^CNT_W−1 with no wrap.
- Only one violation per edge; the state table is exhaustive, so none conflict.
- enable=0 at an edge: state←IDLE, wcnt←0, err←0. err_code and err_cnt hold. Checking resumes at the first edge with enable=1, evaluated from IDLE.

## Timing
- Reset (async assert, any time, including mid-WAIT): state=IDLE, wcnt=0, busy=0, err=0, err_code=0, err_cnt=0. Outputs go low immediately, not at the next edge.
- Release: first evaluation at the first rising edge with rst_n=1.
- Latency:
  - A violation sampled at edge E drives err high from E until E+1.
  - err_code and err_cnt update at E.
  - busy is registered: high from the edge entering WAIT until the edge returning to IDLE.
- Timeout window:
  - req first sampled at E0.
  - ack accepted at E0..E_TIMEOUT.
  - TIMEOUT=1: ack must be at E0 or E1; ack=0 at E1 flags TIMEOUT at E1.
- Back-to-back: ack+req at the same edge in WAIT completes the current transfer. A new request is recognised only if req is still high at the next edge (evaluated in IDLE).
- Consecutive violations on consecutive edges produce err high on consecutive cycles, each counted.

## Test plan
- Reset, then req high at edge 3 and ack at edge 5 -> busy high edges 3–5, err never asserted, err_cnt=0.
- TIMEOUT=4: req held high, no ack -> err pulse after edge E4, err_code=3, err_cnt=1, busy stays high. Ack at E7 -> IDLE, no second error.
- req high 2 edges then low without ack -> err pulse, err_code=1. Then ack alone while idle -> second pulse, err_code=2, err_cnt=2.
- CNT_W=2: 5 ack-without-req pulses -> err_cnt saturates at 3, err pulses 5 times.
- rst_n dropped mid-WAIT asynchronously -> busy, err, err_cnt go 0 before the next edge. req still high after release -> fresh WAIT, wcnt restarts at 1.
- enable=0 during WAIT, req dropped -> no error. enable=1 with ack=1, req=0 -> ACK_NO_REQ flagged.

Source files
------------

// File: rtl/m_handshake_assert.sv
// rtl/m_handshake_assert.sv - req/ack handshake protocol checker with registered violation strobe
module m_handshake_assert #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             req,
    input  logic             ack,
    output logic             busy,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int WC_W = $clog2(TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(TIMEOUT);

    localparam logic [1:0] CODE_NONE       = 2'd0;
    localparam logic [1:0] CODE_REQ_DROP   = 2'd1;
    localparam logic [1:0] CODE_ACK_NO_REQ = 2'd2;
    localparam logic [1:0] CODE_TIMEOUT    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t          state, next_state;
    logic [WC_W-1:0] wcnt, next_wcnt;
    logic            viol;
    logic [1:0]      viol_code;

    always_comb begin
        next_state = state;
        next_wcnt  = wcnt;
        viol       = 1'b0;
        viol_code  = CODE_NONE;
        if (!enable) begin
            next_state = S_IDLE;
            next_wcnt  = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req && !ack) begin
                        next_state = S_WAIT;
                        next_wcnt  = WC_W'(1);
                    end else if (!req && ack) begin
                        viol      = 1'b1;
                        viol_code = CODE_ACK_NO_REQ;
                    end
                end
                S_WAIT: begin
                    if (ack) begin
                        next_state = S_IDLE;
                        next_wcnt  = '0;
                    end else if (!req) begin
                        next_state = S_IDLE;
                        next_wcnt  = '0;
                        viol       = 1'b1;
                        viol_code  = CODE_REQ_DROP;
                    end else if (wcnt == WC_MAX) begin
                        next_state = S_HOLD;
                        viol       = 1'b1;
                        viol_code  = CODE_TIMEOUT;
                    end else begin
                        next_wcnt = wcnt + WC_W'(1);
                    end
                end
                S_HOLD: begin
                    // Request already flagged; a late ack or a drop just closes it quietly
                    if (ack || !req) begin
                        next_state = S_IDLE;
                        next_wcnt  = '0;
                    end
                end
                default: begin
                    next_state = S_IDLE;
                    next_wcnt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            wcnt     <= '0;
            err      <= 1'b0;
            err_code <= CODE_NONE;
            err_cnt  <= '0;
        end else begin
            state <= next_state;
            wcnt  <= next_wcnt;
            err   <= viol;
            if (viol) begin
                err_code <= viol_code;
                if (err_cnt != {CNT_W{1'b1}})
                    err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

    assign busy = (state != S_IDLE);
endmodule
